// File: rtl/alu1_bit.sv
// One-bit ALU slice: AND/OR/NOR, add/sub and SLT pass-through, with registered,
// valid-qualified outputs (one-cycle latency).
module alu1_bit (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic lessinp,
  input  logic cin,
  input  logic ainv,
  input  logic binv,
  input  logic opcodeA,
  input  logic opcodeB,
  output logic cout,
  output logic result,
  output logic set,
  output logic overflow,
  output logic out_valid
);

  logic a_p, b_p, sum, co, ovf, res_c;
  logic result_d, result_q;
  logic cout_d, cout_q;
  logic set_d, set_q;
  logic overflow_d, overflow_q;
  logic out_valid_d, out_valid_q;

  always_comb begin
    a_p = a ^ ainv;
    b_p = b ^ binv;
    sum = a_p ^ b_p ^ cin;
    co  = (a_p & b_p) | (cin & (a_p ^ b_p));
    ovf = cin ^ co;
    unique case ({opcodeA, opcodeB})
      2'b00:   res_c = a_p & b_p;
      2'b01:   res_c = a_p | b_p;
      2'b10:   res_c = sum;
      default: res_c = lessinp;
    endcase
  end

  // Data outputs only load on a valid cycle; otherwise they hold.
  always_comb begin
    result_d    = result_q;
    cout_d      = cout_q;
    set_d       = set_q;
    overflow_d  = overflow_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      result_d   = res_c;
      cout_d     = co;
      set_d      = sum ^ ovf;
      overflow_d = ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= 1'b0;
      cout_q      <= 1'b0;
      set_q       <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      cout_q      <= cout_d;
      set_q       <= set_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign cout      = cout_q;
  assign set       = set_q;
  assign overflow  = overflow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu1_bit.sv
// Self-checking bench for alu1_bit: directed test-plan cases, an exhaustive sweep and
// randomized valid/reset traffic against an arithmetic reference model.
module tb_alu1_bit;

  logic clk = 1'b0;
  logic reset, in_valid, a, b, lessinp, cin, ainv, binv, opcodeA, opcodeB;
  logic cout, result, set, overflow, out_valid;

  int checks = 0;
  int errors = 0;

  // Expected registered state.
  logic m_result = 1'b0, m_cout = 1'b0, m_set = 1'b0, m_ovf = 1'b0, m_valid = 1'b0;

  always #5 clk = ~clk;

  alu1_bit dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .lessinp  (lessinp),
    .cin      (cin),
    .ainv     (ainv),
    .binv     (binv),
    .opcodeA  (opcodeA),
    .opcodeB  (opcodeB),
    .cout     (cout),
    .result   (result),
    .set      (set),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  task automatic check_eq(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Vector layout: {a, b, lessinp, cin, ainv, binv, opcodeA, opcodeB}.
  task automatic step(input logic [7:0] v, input logic iv, input logic rst);
    int ap, bp, ci, total, sum, co, ovf, res;
    {a, b, lessinp, cin, ainv, binv, opcodeA, opcodeB} = v;
    in_valid = iv;
    reset    = rst;
    ap    = int'(v[7] ^ v[3]);
    bp    = int'(v[6] ^ v[2]);
    ci    = int'(v[4]);
    total = ap + bp + ci;
    sum   = total % 2;
    co    = total / 2;
    ovf   = (ci + co) % 2;
    case (v[1:0])
      2'd0:    res = ap * bp;
      2'd1:    res = (ap + bp > 0) ? 1 : 0;
      2'd2:    res = sum;
      default: res = int'(v[5]);
    endcase
    if (rst) begin
      {m_result, m_cout, m_set, m_ovf, m_valid} = 5'b0;
    end else begin
      m_valid = iv;
      if (iv) begin
        m_result = res[0];
        m_cout   = co[0];
        m_ovf    = ovf[0];
        m_set    = 1'(sum + ovf);
      end
    end
    @(posedge clk);
    #1;
    check_eq("result", result, m_result);
    check_eq("cout", cout, m_cout);
    check_eq("set", set, m_set);
    check_eq("overflow", overflow, m_ovf);
    check_eq("out_valid", out_valid, m_valid);
  endtask

  function automatic logic [7:0] vec(input logic va, input logic vb, input logic vl,
                                     input logic vc, input logic vai, input logic vbi,
                                     input logic [1:0] op);
    return {va, vb, vl, vc, vai, vbi, op};
  endfunction

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    {a, b, lessinp, cin, ainv, binv, opcodeA, opcodeB} = 8'h00;

    // Reset held with random operands and in_valid=1.
    for (int i = 0; i < 2; i++) begin
      step(8'($urandom), 1'b1, 1'b1);
      check_eq("rst_result", result, 1'b0);
      check_eq("rst_valid", out_valid, 1'b0);
    end

    // Logic ops.
    step(vec(1, 0, 0, 0, 0, 0, 2'b00), 1, 0);
    check_eq("and_res", result, 1'b0);
    step(vec(1, 0, 0, 0, 0, 0, 2'b01), 1, 0);
    check_eq("or_res", result, 1'b1);
    step(vec(0, 1, 0, 0, 1, 1, 2'b00), 1, 0);
    check_eq("nor01_res", result, 1'b0);
    check_eq("nor01_cout", cout, 1'b0);
    step(vec(0, 0, 0, 0, 1, 1, 2'b00), 1, 0);
    check_eq("nor00_res", result, 1'b1);
    check_eq("nor00_cout", cout, 1'b1);

    // Add / sub.
    step(vec(1, 0, 0, 1, 0, 0, 2'b10), 1, 0);
    check_eq("add1_cout", cout, 1'b1);
    check_eq("add1_res", result, 1'b0);
    check_eq("add1_ovf", overflow, 1'b0);
    step(vec(0, 1, 0, 0, 0, 0, 2'b10), 1, 0);
    check_eq("add2_cout", cout, 1'b0);
    check_eq("add2_res", result, 1'b1);
    step(vec(1, 1, 0, 1, 0, 1, 2'b10), 1, 0);
    check_eq("sub_cout", cout, 1'b1);
    check_eq("sub_res", result, 1'b0);

    // SLT.
    step(vec(0, 1, 1, 1, 0, 1, 2'b11), 1, 0);
    check_eq("slt_res", result, 1'b1);
    check_eq("slt_cout", cout, 1'b0);
    check_eq("slt_ovf", overflow, 1'b1);
    check_eq("slt_set", set, 1'b0);
    step(vec(0, 1, 0, 1, 0, 1, 2'b11), 1, 0);
    check_eq("slt0_res", result, 1'b0);

    // Valid pulse then hold while inputs change; then reset wins over in_valid.
    step(vec(1, 1, 0, 0, 0, 0, 2'b00), 1, 0);
    check_eq("pulse_valid", out_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(8'($urandom), 0, 0);
      check_eq("hold_valid", out_valid, 1'b0);
      check_eq("hold_res", result, 1'b1);
    end
    step(vec(1, 1, 0, 0, 0, 0, 2'b00), 1, 1);
    check_eq("rstwin_res", result, 1'b0);
    check_eq("rstwin_valid", out_valid, 1'b0);

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 256; i++) step(8'(i), 1, 0);

    // Randomized traffic with sporadic idle cycles and resets.
    for (int i = 0; i < 400; i++)
      step(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
